multdiv: RTL and testbench

//   Multicycle signed multiply/divide unit for the 32-bit processor. It works alongside the

---
 rtl/multdiv.sv | 150 +++++++++++++++
 tb/tb_multdiv.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multdiv.sv
// Multicycle signed multiply/divide unit: radix-2 Booth multiply, restoring divide.
// A start pulse launches an operation; the result returns with a one-cycle ready strobe.
module multdiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction

    // Product overflows the result word unless bits [2W-1:W-1] are pure sign extension.
    function automatic logic mulOverflow(input logic [WIDTH:0] top);
        return (|top) && !(&top);
    endfunction

    logic [1:0]              state;
    logic [CNT_W-1:0]        count;
    logic signed [WIDTH-1:0] mulA;
    logic signed [WIDTH:0]   mulAcc;
    logic [WIDTH-1:0]        mulLo;
    logic                    mulQm1;
    logic [WIDTH-1:0]        divRem;
    logic [WIDTH-1:0]        divQuo;
    logic [WIDTH-1:0]        divisor;
    logic                    negQuo;
    logic                    divOvf;

    logic signed [WIDTH:0] aExt;
    logic signed [WIDTH:0] accSum;
    logic [WIDTH:0]        remShift;

    // Accumulator carries one guard bit so adding/subtracting the most negative A cannot wrap.
    always_comb begin
        aExt = $signed({mulA[WIDTH-1], mulA});
        case ({mulLo[0], mulQm1})
            2'b01:   accSum = mulAcc + aExt;
            2'b10:   accSum = mulAcc - aExt;
            default: accSum = mulAcc;
        endcase
        remShift = {1'b0, divRem[WIDTH-1:0]} << 1 | {{WIDTH{1'b0}}, divQuo[WIDTH-1]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            mulA           <= '0;
            mulAcc         <= '0;
            mulLo          <= '0;
            mulQm1         <= 1'b0;
            divRem         <= '0;
            divQuo         <= '0;
            divisor        <= '0;
            negQuo         <= 1'b0;
            divOvf         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT) begin
                mulA   <= data_operandA;
                mulAcc <= '0;
                mulLo  <= data_operandB;
                mulQm1 <= 1'b0;
                count  <= '0;
                busy   <= 1'b1;
                state  <= MUL;
            end else if (ctrl_DIV) begin
                divRem  <= '0;
                divQuo  <= magnitude(data_operandA);
                divisor <= magnitude(data_operandB);
                negQuo  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                divOvf  <= (data_operandA == MIN_NEG) && (&data_operandB);
                count   <= '0;
                busy    <= 1'b1;
                state   <= DIV;
            end else begin
                case (state)
                    MUL: begin
                        if (count == LAST) begin
                            data_result    <= mulLo;
                            data_exception <= mulOverflow({mulAcc[WIDTH-1:0], mulLo[WIDTH-1]});
                            data_resultRDY <= 1'b1;
                            busy           <= 1'b0;
                            state          <= DONE;
                        end else begin
                            mulAcc <= {accSum[WIDTH], accSum[WIDTH:1]};
                            mulLo  <= {accSum[0], mulLo[WIDTH-1:1]};
                            mulQm1 <= mulLo[0];
                            count  <= count + 1'b1;
                        end
                    end
                    DIV: begin
                        if (divisor == '0) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                            data_resultRDY <= 1'b1;
                            busy           <= 1'b0;
                            state          <= DONE;
                        end else if (count == LAST) begin
                            data_result    <= negQuo ? negate(divQuo) : divQuo;
                            data_exception <= divOvf;
                            data_resultRDY <= 1'b1;
                            busy           <= 1'b0;
                            state          <= DONE;
                        end else begin
                            if (remShift >= {1'b0, divisor}) begin
                                divRem <= WIDTH'(remShift - {1'b0, divisor});
                                divQuo <= {divQuo[WIDTH-2:0], 1'b1};
                            end else begin
                                divRem <= remShift[WIDTH-1:0];
                                divQuo <= {divQuo[WIDTH-2:0], 1'b0};
                            end
                            count <= count + 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv.sv
// Bench for multdiv: directed and random operations checked against an arithmetic model.
module tb_multdiv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        mult = 1'b0;
    logic        div = 1'b0;
    logic [31:0] result;
    logic        exc;
    logic        rdy;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    multdiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock),
        .reset(reset),
        .data_operandA(opA),
        .data_operandB(opB),
        .ctrl_MULT(mult),
        .ctrl_DIV(div),
        .data_result(result),
        .data_exception(exc),
        .data_resultRDY(rdy),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Plain 64-bit arithmetic reference; SV signed division truncates toward zero.
    task automatic model(input bit isMul, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ex);
        longint full;
        if (isMul) begin
            full = longint'($signed(a)) * longint'($signed(b));
        end else if (b == 0) begin
            res = 0;
            ex = 1'b1;
            return;
        end else begin
            full = longint'($signed(a)) / longint'($signed(b));
        end
        res = full[31:0];
        ex = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    endtask

    task automatic runOp(input bit isMul, input bit both, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        logic [31:0] expRes;
        logic        expExc;
        int          expLat;
        int          lat;
        model(isMul, a, b, expRes, expExc);
        expLat = (!isMul && b == 0) ? 1 : 33;
        @(negedge clock);
        opA = a;
        opB = b;
        mult = isMul;
        div = !isMul || both;
        @(posedge clock);
        #1;
        mult = 1'b0;
        div = 1'b0;
        opA = $urandom;
        opB = $urandom;
        check({tag, " busy after start"}, busy, 1);
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!rdy && lat < 60);
        check({tag, " latency"}, lat, expLat);
        check({tag, " result"}, result, expRes);
        check({tag, " exception"}, exc, expExc);
        check({tag, " busy at ready"}, busy, 0);
        @(posedge clock);
        #1;
        check({tag, " ready one cycle"}, rdy, 0);
        check({tag, " result held"}, result, expRes);
    endtask

    initial begin
        logic        sawRdy;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rm;

        repeat (2) @(posedge clock);
        #1;
        check("reset result", result, 0);
        check("reset exception", exc, 0);
        check("reset ready", rdy, 0);
        check("reset busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;

        runOp(1, 0, 32'd7, 32'hFFFF_FFFD, "mul 7*-3");
        runOp(1, 0, 32'h0001_0000, 32'h0001_0000, "mul overflow");
        runOp(0, 0, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        runOp(0, 0, 32'd5, 32'd0, "div by zero");
        runOp(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
        runOp(1, 0, 32'h8000_0000, 32'h8000_0000, "mul minneg^2");
        runOp(1, 1, 32'd6, 32'd0, "both ctrl mult wins");

        for (int i = 0; i < 16; i++) begin
            rm = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) begin
                ra = 32'($urandom_range(0, 4000)) - 32'd2000;
                rb = 32'($urandom_range(0, 4000)) - 32'd2000;
            end else if (i % 4 == 2) begin
                rb = 32'($urandom_range(1, 20));
            end else if (i % 7 == 3) begin
                rb = 32'd0;
            end
            runOp(rm, 0, ra, rb, "random op");
        end

        // Abort: a DIV started ten cycles into a MULT replaces it with a single ready.
        @(negedge clock);
        opA = 32'd3;
        opB = 32'd4;
        mult = 1'b1;
        @(posedge clock);
        #1;
        mult = 1'b0;
        sawRdy = 1'b0;
        repeat (9) begin
            @(posedge clock);
            #1;
            sawRdy |= rdy;
        end
        check("abort no early ready", sawRdy, 0);
        runOp(0, 0, 32'd100, 32'd7, "abort div 100/7");

        // Reset in the middle of a multiply clears outputs at once and suppresses ready.
        @(negedge clock);
        opA = 32'd9;
        opB = 32'd9;
        mult = 1'b1;
        @(posedge clock);
        #1;
        mult = 1'b0;
        repeat (14) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("midop reset result", result, 0);
        check("midop reset exception", exc, 0);
        check("midop reset busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        sawRdy = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            sawRdy |= rdy;
        end
        check("midop reset no ready", sawRdy, 0);
        runOp(1, 0, 32'hFFFF_FFFE, 32'd50000, "mul after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
